// File: rtl/alu_ctrl.sv
// alu_ctrl: valid/ready command sequencer that drives an 8-bit combinational ALU
// with an accumulator. Optional zero flag on the response channel: ALU_CTRL_ZFLAG_EN.
module alu_ctrl #(
    parameter int unsigned          DW       = 8,
    parameter logic [DW-1:0]        ACC_INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [3:0]      cmd_op,
    input  logic [2:0]      cmd_amt,
    input  logic [DW-1:0]   cmd_data,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [4:0]      alu_s,
    input  logic [DW-1:0]   alu_f,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_data,
    output logic            busy
`ifdef ALU_CTRL_ZFLAG_EN
    ,
    output logic            rsp_zero
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [3:0] {
        OP_LOAD = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_OR   = 4'd3,
        OP_AND  = 4'd4,
        OP_NOR  = 4'd5,
        OP_NAND = 4'd6,
        OP_NOT  = 4'd7,
        OP_NEG  = 4'd8,
        OP_CLR  = 4'd9,
        OP_SET  = 4'd10,
        OP_SHL  = 4'd11,
        OP_SHR  = 4'd12,
        OP_ROL  = 4'd13,
        OP_ROR  = 4'd14,
        OP_READ = 4'd15
    } cmd_op_e;

    localparam logic [4:0] S_PASS_A = 5'b10100;
    localparam logic [4:0] S_PASS_B = 5'b10101;
    localparam logic [4:0] S_NEG    = 5'b10110;
    localparam logic [4:0] S_CLR    = 5'b10000;
    localparam logic [4:0] S_SET    = 5'b10010;
    localparam logic [4:0] S_ADD    = 5'b11000;
    localparam logic [4:0] S_SUB    = 5'b11001;
    localparam logic [4:0] S_OR     = 5'b11010;
    localparam logic [4:0] S_AND    = 5'b11011;
    localparam logic [4:0] S_NOR    = 5'b11100;
    localparam logic [4:0] S_NAND   = 5'b11101;
    localparam logic [4:0] S_NOT    = 5'b11110;

    state_e         r_state;
    state_e         w_next_state;
    cmd_op_e        r_op;
    logic [2:0]     r_rem;
    logic [DW-1:0]  r_data;
    logic [DW-1:0]  r_acc;

    logic           w_accept;
    logic           w_is_shift;
    logic [1:0]     w_step;
    logic [2:0]     w_rem_next;
    logic [4:0]     w_exec_s;

    assign w_accept   = cmd_valid && (r_state == ST_IDLE) && !rst;
    assign w_is_shift = (r_op == OP_SHL) || (r_op == OP_SHR) ||
                        (r_op == OP_ROL) || (r_op == OP_ROR);

    // The ALU shifts at most 3 places per pass, so larger amounts take several passes.
    assign w_step     = (r_rem > 3'd3) ? 2'd3 : r_rem[1:0];
    assign w_rem_next = r_rem - {1'b0, w_step};

    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        w_exec_s = S_PASS_A;
        unique case (r_op)
            OP_LOAD: w_exec_s = S_PASS_B;
            OP_ADD:  w_exec_s = S_ADD;
            OP_SUB:  w_exec_s = S_SUB;
            OP_OR:   w_exec_s = S_OR;
            OP_AND:  w_exec_s = S_AND;
            OP_NOR:  w_exec_s = S_NOR;
            OP_NAND: w_exec_s = S_NAND;
            OP_NOT:  w_exec_s = S_NOT;
            OP_NEG:  w_exec_s = S_NEG;
            OP_CLR:  w_exec_s = S_CLR;
            OP_SET:  w_exec_s = S_SET;
            OP_SHL:  w_exec_s = {3'b000, w_step};
            OP_SHR:  w_exec_s = {3'b001, w_step};
            OP_ROL:  w_exec_s = {3'b010, w_step};
            OP_ROR:  w_exec_s = {3'b011, w_step};
            OP_READ: w_exec_s = S_PASS_A;
            default: w_exec_s = S_PASS_A;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (cmd_op_e'(cmd_op) == OP_READ) ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_is_shift && (w_rem_next != 3'd0)) begin
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic: outside EXEC the ALU is parked on transfer-A of the accumulator.
    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = r_acc;
        alu_b     = '0;
        alu_s     = S_PASS_A;
        unique case (r_state)
            ST_IDLE: cmd_ready = !rst;
            ST_EXEC: begin
                alu_b = r_data;
                alu_s = w_exec_s;
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign busy     = (r_state != ST_IDLE);
    assign rsp_data = r_acc;

    // Command latch and accumulator datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= ACC_INIT;
            r_op   <= OP_LOAD;
            r_rem  <= 3'd0;
            r_data <= '0;
        end else begin
            if (w_accept) begin
                r_op   <= cmd_op_e'(cmd_op);
                r_rem  <= cmd_amt;
                r_data <= cmd_data;
            end
            if (r_state == ST_EXEC) begin
                r_acc <= alu_f;
                if (w_is_shift) begin
                    r_rem <= w_rem_next;
                end
            end
        end
    end

`ifdef ALU_CTRL_ZFLAG_EN
    logic r_zero;

    // Tracks the accumulator write so the flag is ready with the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zero <= (ACC_INIT == '0);
        end else if (r_state == ST_EXEC) begin
            r_zero <= (alu_f == '0);
        end
    end

    assign rsp_zero = r_zero;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl with a behavioural model of the 8-bit ALU.
// Build with +define+ALU_CTRL_ZFLAG_EN to also check the zero flag.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'd0;
    logic [2:0] cmd_amt = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] alu_s;
    logic [7:0] alu_f;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [7:0] rsp_data;
    logic       busy;
`ifdef ALU_CTRL_ZFLAG_EN
    logic       rsp_zero;
`endif

    alu_ctrl #(.DW(8), .ACC_INIT(8'h00)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_amt   (cmd_amt),
        .cmd_data  (cmd_data),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_f     (alu_f),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
`ifdef ALU_CTRL_ZFLAG_EN
        ,
        .rsp_zero  (rsp_zero)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 000ss SHL, 001ss SHR, 010ss ROL, 011ss ROR, 1xxxx logic/arith.
    logic [15:0] rot_l;
    logic [15:0] rot_r;
    always_comb begin
        rot_l = {alu_a, alu_a} << alu_s[1:0];
        rot_r = {alu_a, alu_a} >> alu_s[1:0];
        alu_f = 8'h00;
        case (alu_s)
            5'b10000: alu_f = 8'h00;
            5'b10010: alu_f = 8'hFF;
            5'b10100: alu_f = alu_a;
            5'b10101: alu_f = alu_b;
            5'b10110: alu_f = 8'h00 - alu_a;
            5'b11000: alu_f = alu_a + alu_b;
            5'b11001: alu_f = alu_a - alu_b;
            5'b11010: alu_f = alu_a | alu_b;
            5'b11011: alu_f = alu_a & alu_b;
            5'b11100: alu_f = ~(alu_a | alu_b);
            5'b11101: alu_f = ~(alu_a & alu_b);
            5'b11110: alu_f = ~alu_a;
            default: begin
                case (alu_s[4:2])
                    3'b000:  alu_f = alu_a << alu_s[1:0];
                    3'b001:  alu_f = alu_a >> alu_s[1:0];
                    3'b010:  alu_f = rot_l[15:8];
                    3'b011:  alu_f = rot_r[7:0];
                    default: alu_f = 8'h00;
                endcase
            end
        endcase
    end

    int         n_pass = 0;
    int         n_total = 0;
    int         busy_cnt;
    int         rsp_cycles;
    logic [4:0] pass_s[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [2:0] amt, input logic [7:0] data,
                         input string tag);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = data;
        @(negedge clk);
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) check({tag, "_accept"}, 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Counts negedges from accept to rsp_valid, logging alu_s on each EXEC cycle.
    task automatic wait_rsp(input logic [7:0] exp_data, input int exp_cycles, input string tag);
        rsp_cycles = 0;
        busy_cnt   = 0;
        pass_s.delete();
        while (rsp_cycles < 40) begin
            @(negedge clk);
            rsp_cycles++;
            if (busy) busy_cnt++;
            if (rsp_valid) break;
            pass_s.push_back(alu_s);
        end
        check({tag, "_valid"}, 32'(rsp_valid), 1);
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_lat"}, rsp_cycles, exp_cycles);
        tick();
    endtask

    task automatic run(input logic [3:0] op, input logic [2:0] amt, input logic [7:0] data,
                       input logic [7:0] exp_data, input int exp_cycles, input string tag);
        issue(op, amt, data, tag);
        wait_rsp(exp_data, exp_cycles, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bp_ok;
        logic saw_rsp;

        // Reset state.
        tick();
        tick();
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 32'h00);
`ifdef ALU_CTRL_ZFLAG_EN
        check("rst_zero", 32'(rsp_zero), 1);
`endif
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 1);
        check("idle_alu_s", 32'(alu_s), 32'h14);
        check("idle_alu_b", 32'(alu_b), 32'h00);
        tick();

        // LOAD then ADD with wrap.
        run(4'd0, 3'd0, 8'h3C, 8'h3C, 2, "load3c");
        run(4'd1, 3'd0, 8'hD0, 8'h0C, 2, "add_wrap");
        check("post_add_busy", 32'(busy), 0);

        // ROL by 7 splits into 3, 3, 1.
        run(4'd0, 3'd0, 8'h81, 8'h81, 2, "load81");
        run(4'd13, 3'd7, 8'h00, 8'hC0, 4, "rol7");
        check("rol7_npass", pass_s.size(), 3);
        if (pass_s.size() == 3) begin
            check("rol7_p1", 32'(pass_s[0]), 32'h0B);
            check("rol7_p2", 32'(pass_s[1]), 32'h0B);
            check("rol7_p3", 32'(pass_s[2]), 32'h09);
        end
        check("rol7_busy", busy_cnt, 4);

        // Zero-amount shift still takes one pass; SHL 5 = 3 + 2.
        run(4'd0, 3'd0, 8'hF0, 8'hF0, 2, "loadf0");
        run(4'd12, 3'd0, 8'h00, 8'hF0, 2, "shr0");
        check("shr0_npass", pass_s.size(), 1);
        if (pass_s.size() == 1) check("shr0_s", 32'(pass_s[0]), 32'h04);
        run(4'd11, 3'd5, 8'h00, 8'h00, 3, "shl5");
        check("shl5_npass", pass_s.size(), 2);
        if (pass_s.size() == 2) begin
            check("shl5_p1", 32'(pass_s[0]), 32'h03);
            check("shl5_p2", 32'(pass_s[1]), 32'h02);
        end

        // NEG then READ with no EXEC cycle.
        run(4'd0, 3'd0, 8'h05, 8'h05, 2, "load05");
        run(4'd8, 3'd0, 8'h00, 8'hFB, 2, "neg");
        run(4'd15, 3'd0, 8'h00, 8'hFB, 1, "read");
        check("read_npass", pass_s.size(), 0);

        // Backpressure: RESP held for 10 cycles with a pending command.
        rsp_ready = 1'b0;
        run(4'd0, 3'd0, 8'h5A, 8'h5A, 2, "bp_load");
        cmd_valid = 1'b1;
        cmd_op    = 4'd9;
        cmd_amt   = 3'd0;
        cmd_data  = 8'h00;
        bp_ok     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(rsp_valid && rsp_data == 8'h5A && !cmd_ready)) bp_ok = 1'b0;
            tick();
        end
        check("bp_hold", 32'(bp_ok), 1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_hs_cmd_ready", 32'(cmd_ready), 0);
        tick();
        @(negedge clk);
        check("bp_after_cmd_ready", 32'(cmd_ready), 1);
        check("bp_after_rsp_valid", 32'(rsp_valid), 0);
        tick();
        cmd_valid = 1'b0;
        wait_rsp(8'h00, 2, "bp_next");

        // Reset during pass 2 of ROR 6 abandons the command.
        run(4'd0, 3'd0, 8'h77, 8'h77, 2, "load77");
        issue(4'd14, 3'd6, 8'h00, "ror6");
        @(negedge clk);
        check("ror6_p1", 32'(alu_s), 32'h0F);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("ror6_p2", 32'(alu_s), 32'h0F);
        check("ror6_rst_cmd_ready", 32'(cmd_ready), 0);
        tick();
        @(negedge clk);
        check("ror6_rst_busy", 32'(busy), 0);
        check("ror6_rst_rsp_valid", 32'(rsp_valid), 0);
        check("ror6_rst_acc", 32'(rsp_data), 32'h00);
        tick();
        rst = 1'b0;
        saw_rsp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        check("ror6_no_rsp", 32'(saw_rsp), 0);
`ifdef ALU_CTRL_ZFLAG_EN
        check("ror6_zero", 32'(rsp_zero), 1);
`endif
        tick();
        run(4'd10, 3'd0, 8'h00, 8'hFF, 2, "set");
`ifdef ALU_CTRL_ZFLAG_EN
        check("set_zero", 32'(rsp_zero), 0);
`endif
        run(4'd9, 3'd0, 8'h00, 8'h00, 2, "clr");
`ifdef ALU_CTRL_ZFLAG_EN
        check("clr_zero", 32'(rsp_zero), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
Name: alu_ctrl

Overview:
Sequential initiator that drives the 8-bit combinational ALU (5-bit opcode S, operands A/B, result F) from a valid/ready command stream.
- Holds an 8-bit accumulator and maps 4-bit commands onto ALU opcodes.
- Splits shift and rotate amounts of 0..7 into ALU passes of at most 3.
- Returns the accumulator on a valid/ready response channel.
- Sits between a command source (sequencer or testbench) and the ALU instance.

Parameters:
DW, 8, datapath width; fixed at 8 to match the ALU.
ACC_INIT, 8'h00, accumulator value after reset.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block accepts a command this cycle
cmd_op  input  4  command code
cmd_amt  input  3  shift/rotate amount 0..7
cmd_data  input  8  operand
alu_a  output  8  to ALU A
alu_b  output  8  to ALU B
alu_s  output  5  to ALU S
alu_f  input  8  from ALU F, combinational result
rsp_valid  output  1  response present
rsp_ready  input  1  response consumer ready
rsp_data  output  8  accumulator value
busy  output  1  state is not IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous, active-high.
- Reset (at a clk edge with rst=1): state=IDLE, acc=ACC_INIT, rsp_valid=0, rem=0, latched op/amt/data=0.
  - cmd_ready=0 while rst=1.
  - Reset mid-EXEC or mid-RESP abandons the command; no response is ever issued for it.
- States: IDLE, EXEC, RESP.
  - cmd_ready = (state==IDLE) && !rst.
  - busy = (state!=IDLE).
- IDLE: on cmd_valid && cmd_ready, latch op/amt/data and set rem=amt. Next state is RESP if op=READ, else EXEC.
- EXEC: one ALU pass per cycle.
  - alu_a=acc, alu_b=data_r, alu_s decoded as below.
  - At the edge: acc<=alu_f.
  - Shift/rotate ops: step=min(rem,3); rem<=rem-step; stay in EXEC while rem-step!=0, else go to RESP.
  - All other ops: single pass, then RESP.
- Shift/rotate pass counts:
  - amt=0: exactly one pass with step 00; acc unchanged.
  - amt=7: passes 3, 3, 1.
- RESP: rsp_valid=1, rsp_data=acc, both held stable until rsp_ready=1. Then go to IDLE.
  - A new command is accepted no earlier than the cycle after the handshake.
- IDLE and RESP ALU drive: alu_s=5'b10100 (transfer A), alu_a=acc, alu_b=0.
- rsp_data = acc in every state; it is qualified only by rsp_valid.
- Op codes (cmd_op -> alu_s):
  - 0 LOAD -> 10101 (acc=B)
  - 1 ADD -> 11000
  - 2 SUB -> 11001 (acc-B)
  - 3 OR -> 11010
  - 4 AND -> 11011
  - 5 NOR -> 11100
  - 6 NAND -> 11101
  - 7 NOT -> 11110 (~acc)
  - 8 NEG -> 10110 (-acc)
  - 9 CLR -> 10000
  - 10 SET -> 10010 (acc=8'hFF)
  - 11 SHL -> 000ss
  - 12 SHR -> 001ss
  - 13 ROL -> 010ss
  - 14 ROR -> 011ss
  - 15 READ -> no ALU pass
  - ss = step for the current pass.
- Arithmetic: 8-bit, wraps modulo 256; no carry is kept.
- Latency (accept at edge T, P passes):
  - EXEC occupies cycles T+1..T+P.
  - rsp_valid rises after edge T+P+1 (T+1 for READ).
  - Throughput: one command per P+2 cycles with rsp_ready tied high.
- Backpressure: rsp_ready low holds RESP indefinitely; cmd_ready stays 0 throughout.

Optional Feature:
- Macro: ALU_CTRL_ZFLAG_EN.
- Defined: adds output port rsp_zero (1 bit).
  - Registered; equals (acc==0), updated on every acc write.
  - Valid whenever rsp_valid=1; reset value 1 if ACC_INIT==0, else 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset then LOAD 8'h3C, ADD 8'hD0 -> responses 8'h3C then 8'h0C (wrap); each rsp_valid exactly 2 cycles after accept.
2. LOAD 8'h81, ROL amt=7 -> passes observed on alu_s: 01011, 01011, 01001; busy for 4 cycles; rsp_data=8'hC0.
3. LOAD 8'hF0, SHR amt=0 -> one EXEC pass with alu_s=00100; rsp_data=8'hF0. Then SHL amt=5 -> rsp_data=8'h00.
4. LOAD 8'h05, NEG, READ -> responses 8'h05, 8'hFB, 8'hFB; READ response 1 cycle after accept with no EXEC cycle.
5. rsp_ready held low 10 cycles during RESP with cmd_valid=1 -> rsp_data stable, cmd_ready=0 until the handshake; next command is accepted the cycle after.
6. rst asserted during pass 2 of ROR amt=6 -> no response; acc=ACC_INIT; with ALU_CTRL_ZFLAG_EN, CLR gives rsp_zero=1 and SET gives rsp_zero=0.
